// File: rtl/mem_responder_pkg.sv
// Shared bus definitions for the processor/memory interface: command encoding,
// tag width, default latency and the in-flight transaction record.
package sys_defs;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'd0,
      BUS_LOAD  = 2'd1,
      BUS_STORE = 2'd2
   } bus_command_t;

   localparam int unsigned MEM_TAG_W           = 4;
   localparam int unsigned MEM_LATENCY_DEFAULT = 10;
   // Word index of a 32-bit byte address (addr[31:3]); the responder slices what it needs.
   localparam int unsigned MEM_IDX_W           = 29;

   typedef struct packed {
      logic                 valid;
      logic [MEM_TAG_W-1:0] tag;
      logic [MEM_IDX_W-1:0] idx;
      logic                 is_load;
   } mem_inflight_t;

   // Tags run 1..15 and skip 0, which means "rejected" / "no completion".
   function automatic logic [MEM_TAG_W-1:0] tag_after(input logic [MEM_TAG_W-1:0] t);
      return (t == '1) ? MEM_TAG_W'(1) : t + MEM_TAG_W'(1);
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Processor/memory bus: request side driven by the initiator, response side by memory.
interface mem_responder_if;
   import sys_defs::*;

   logic [1:0]           proc2mem_command;
   logic [31:0]          proc2mem_addr;
   logic [63:0]          proc2mem_data;
   logic [MEM_TAG_W-1:0] mem2proc_response;
   logic [63:0]          mem2proc_data;
   logic [MEM_TAG_W-1:0] mem2proc_tag;

   modport master (
      output proc2mem_command, proc2mem_addr, proc2mem_data,
      input  mem2proc_response, mem2proc_data, mem2proc_tag
   );

   modport slave (
      input  proc2mem_command, proc2mem_addr, proc2mem_data,
      output mem2proc_response, mem2proc_data, mem2proc_tag
   );
endinterface

// File: rtl/mem_responder_delay_line.sv
// Fixed-latency shift register of in-flight transactions; reset discards everything in flight.
module mem_delay_line
   import sys_defs::*;
#(
   parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEFAULT
) (
   input  logic          clock,
   input  logic          reset,
   input  mem_inflight_t entry,
   output mem_inflight_t tail
);

   mem_inflight_t stage [MEM_LATENCY];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < MEM_LATENCY; i++) stage[i] <= '0;
      end else begin
         stage[0] <= entry;
         for (int unsigned i = 1; i < MEM_LATENCY; i++) stage[i] <= stage[i-1];
      end
   end

   assign tail = stage[MEM_LATENCY-1];

endmodule

// File: rtl/mem_responder.sv
// Memory-side bus responder with fixed latency and in-order completion.
// Optional MEM_STALL_INJECT_EN adds LFSR-driven pseudo-random request rejection.
module mem_responder
   import sys_defs::*;
#(
   parameter int unsigned MEM_WORDS       = 256,
   parameter int unsigned MEM_LATENCY     = MEM_LATENCY_DEFAULT,
   parameter int unsigned MAX_OUTSTANDING = 8
) (
   input logic           clock,
   input logic           reset,
   mem_responder_if.slave bus
);

   localparam int unsigned          IDX_W    = $clog2(MEM_WORDS);
   localparam logic [MEM_TAG_W-1:0] MAX_OUT  = MEM_TAG_W'(MAX_OUTSTANDING);

   logic [63:0]          mem [MEM_WORDS];
   logic [MEM_TAG_W-1:0] next_tag;
   logic [MEM_TAG_W-1:0] outstanding;
   logic                 is_request;
   logic                 stall;
   logic                 accept;
   logic                 complete;
   logic [IDX_W-1:0]     req_idx;
   mem_inflight_t        entry;
   mem_inflight_t        tail;
   logic                 unused_bits;

`ifdef MEM_STALL_INJECT_EN
   logic [15:0] lfsr;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) lfsr <= 16'hACE1;
      else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   assign stall = (lfsr[2:0] == 3'b000);
`else
   assign stall = 1'b0;
`endif

   assign is_request = (bus.proc2mem_command == BUS_LOAD) || (bus.proc2mem_command == BUS_STORE);
   // A completion this cycle only frees its slot from the next cycle on.
   assign accept     = !reset && is_request && (outstanding < MAX_OUT) && !stall;
   assign complete   = tail.valid;
   assign req_idx    = bus.proc2mem_addr[3 +: IDX_W];

   always_comb begin
      entry         = '0;
      entry.valid   = accept;
      entry.tag     = next_tag;
      entry.idx     = bus.proc2mem_addr[31:3];
      entry.is_load = (bus.proc2mem_command == BUS_LOAD);
   end

   mem_delay_line #(.MEM_LATENCY(MEM_LATENCY)) u_delay (
      .clock (clock),
      .reset (reset),
      .entry (entry),
      .tail  (tail)
   );

   // Backing array is deliberately not reset.
   always_ff @(posedge clock) begin
      if (accept && (bus.proc2mem_command == BUS_STORE)) mem[req_idx] <= bus.proc2mem_data;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         next_tag    <= MEM_TAG_W'(1);
         outstanding <= '0;
      end else begin
         if (accept) next_tag <= tag_after(next_tag);
         case ({accept, complete})
            2'b10:   outstanding <= outstanding + MEM_TAG_W'(1);
            2'b01:   outstanding <= outstanding - MEM_TAG_W'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

   assign bus.mem2proc_response = accept ? next_tag : '0;
   assign bus.mem2proc_tag      = tail.valid ? tail.tag : '0;
   assign bus.mem2proc_data     = (tail.valid && tail.is_load) ? mem[tail.idx[IDX_W-1:0]] : '0;

   assign unused_bits = ^{bus.proc2mem_addr[2:0], tail.idx};

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: vector table plus hand sequences,
// with a queue scoreboard predicting every response and completion.
module tb_mem_responder;
   import sys_defs::*;

   localparam int unsigned LAT   = 10;
   localparam int unsigned MAXO  = 8;
   localparam int unsigned WORDS = 256;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int unsigned cyc = 0;

   mem_responder_if bus();

   mem_responder #(
      .MEM_WORDS       (WORDS),
      .MEM_LATENCY     (LAT),
      .MAX_OUTSTANDING (MAXO)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [3:0]  tag;
      logic [7:0]  idx;
      bit          is_load;
      int unsigned due;
   } pend_t;

   typedef struct {
      bit          rst;
      logic [1:0]  cmd;
      logic [31:0] addr;
      logic [63:0] data;
      logic [3:0]  resp;
   } vec_t;

   pend_t       q[$];
   logic [63:0] mmem [WORDS];
   bit          written [WORDS];
   int          checks   = 0;
   int          failures = 0;
   int unsigned m_out;
   logic [3:0]  m_next;
   logic [15:0] m_lfsr;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: completions are checked before this cycle's store lands in mmem.
   always @(negedge clock) begin
      if (reset) begin
         q.delete();
         m_out  = 0;
         m_next = 4'd1;
         m_lfsr = 16'hACE1;
      end else begin
         bit         comp;
         bit         acc;
         logic [7:0] idx;
         comp = 1'b0;
         if (q.size() > 0 && q[0].due == cyc) begin
            comp = 1'b1;
            check("cpl_tag", 64'(bus.mem2proc_tag), 64'(q[0].tag));
            if (!q[0].is_load)
               check("cpl_store_data", bus.mem2proc_data, 64'd0);
            else if (written[q[0].idx])
               check("cpl_load_data", bus.mem2proc_data, mmem[q[0].idx]);
            void'(q.pop_front());
         end else begin
            check("idle_tag", 64'(bus.mem2proc_tag), 64'd0);
            check("idle_data", bus.mem2proc_data, 64'd0);
         end
         acc = (bus.proc2mem_command == 2'd1 || bus.proc2mem_command == 2'd2) && (m_out < MAXO);
`ifdef MEM_STALL_INJECT_EN
         acc    = acc && (m_lfsr[2:0] != 3'b000);
         m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
         check("response", 64'(bus.mem2proc_response), acc ? 64'(m_next) : 64'd0);
         if (acc) begin
            idx = bus.proc2mem_addr[10:3];
            q.push_back('{tag: m_next, idx: idx, is_load: (bus.proc2mem_command == 2'd1), due: cyc + LAT});
            if (bus.proc2mem_command == 2'd2) begin
               mmem[idx]    = bus.proc2mem_data;
               written[idx] = 1'b1;
            end
            m_next = (m_next == 4'd15) ? 4'd1 : m_next + 4'd1;
         end
         m_out = m_out + (acc ? 1 : 0) - (comp ? 1 : 0);
      end
   end

   task automatic drive(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d);
      @(posedge clock);
      #1;
      bus.proc2mem_command = c;
      bus.proc2mem_addr    = a;
      bus.proc2mem_data    = d;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(2'd0, 32'd0, 64'd0);
   endtask

   task automatic do_reset();
      @(posedge clock);
      #1;
      reset = 1'b1;
      bus.proc2mem_command = 2'd0;
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   // Drive one request and compare its same-cycle response against a fixed value.
   task automatic apply(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d,
                        input logic [3:0] resp, input string name);
      drive(c, a, d);
      @(negedge clock);
`ifndef MEM_STALL_INJECT_EN
      check(name, 64'(bus.mem2proc_response), 64'(resp));
`endif
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[$];
      int   r3[20];

      bus.proc2mem_command = 2'd0;
      bus.proc2mem_addr    = 32'd0;
      bus.proc2mem_data    = 64'd0;

      // Store then load to the same word, then a saturating stream of loads.
      vecs.push_back('{rst: 1'b1, cmd: 2'd2, addr: 32'h80, data: 64'h1234, resp: 4'd1});
      vecs.push_back('{rst: 1'b0, cmd: 2'd1, addr: 32'h80, data: 64'h0,    resp: 4'd2});
      r3 = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0, 0, 9, 10, 11, 12, 13, 14, 15, 1, 0};
      for (int i = 0; i < 20; i++)
         vecs.push_back('{rst: (i == 0), cmd: 2'd1, addr: 32'h80, data: 64'h0, resp: 4'(r3[i])});

      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;

      // Reset state before any request.
      @(negedge clock);
      check("reset_response", 64'(bus.mem2proc_response), 64'd0);
      check("reset_tag", 64'(bus.mem2proc_tag), 64'd0);
      check("reset_data", bus.mem2proc_data, 64'd0);

      // Seed array[8], reset (array survives), then load it in post-reset cycle 5.
      apply(2'd2, 32'h40, 64'hDEAD_BEEF, 4'd1, "seed_resp");
      idle(LAT + 2);
      do_reset();
      idle(4);
      apply(2'd1, 32'h40, 64'd0, 4'd1, "t1_resp");
      for (int k = 1; k <= int'(LAT) + 1; k++) begin
         drive(2'd0, 32'd0, 64'd0);
         @(negedge clock);
`ifndef MEM_STALL_INJECT_EN
         check("t1_tag", 64'(bus.mem2proc_tag), (k == int'(LAT)) ? 64'd1 : 64'd0);
         if (k == int'(LAT)) check("t1_data", bus.mem2proc_data, 64'hDEAD_BEEF);
`endif
      end

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rst) do_reset();
         apply(vecs[i].cmd, vecs[i].addr, vecs[i].data, vecs[i].resp, "vec_resp");
      end
      idle(LAT + 2);

      // Tag wrap: 20 spaced-out stores.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         apply(2'd2, 32'(i * 8), 64'(i), 4'((i % 15) + 1), "wrap_resp");
         idle(2);
      end
      idle(LAT + 2);

      // Reset with three loads in flight; nothing may complete afterwards.
      do_reset();
      apply(2'd1, 32'h80, 64'd0, 4'd1, "flush_resp");
      apply(2'd1, 32'h88, 64'd0, 4'd2, "flush_resp");
      apply(2'd1, 32'h90, 64'd0, 4'd3, "flush_resp");
      do_reset();
      idle(LAT + 3);
      apply(2'd1, 32'h80, 64'd0, 4'd1, "post_flush_resp");
      idle(LAT + 2);

      // Random traffic, including command value 3 and aliased upper address bits.
      do_reset();
`ifdef MEM_STALL_INJECT_EN
      for (int i = 0; i < 1000; i++)
`else
      for (int i = 0; i < 300; i++)
`endif
         drive(2'($urandom_range(0, 3)), $urandom, {$urandom, $urandom});
      idle(LAT + 2);

      @(negedge clock);
      check("drain", 64'(q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side end of the processor/memory bus whose initiators are the I-cache and the D-cache/load-store path.
- Accepts one BUS_LOAD/BUS_STORE per cycle and returns a nonzero 4-bit transaction tag the same cycle, or 0 to reject (initiator retries).
- Returns {data, tag} exactly MEM_LATENCY cycles after acceptance.
- Backed by an internal 64-bit-word array; serves as the synthesizable memory model for core-level simulation.

Parameters:
- MEM_WORDS, 256, number of 64-bit words in the backing array (power of 2).
- MEM_LATENCY, 10, cycles from acceptance to completion (>=1).
- MAX_OUTSTANDING, 8, maximum accepted-but-not-completed transactions (1..15).

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- proc2mem_command  input  2  BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2; value 3 is treated as BUS_NONE.
- proc2mem_addr  input  32  byte address; bits [2:0] ignored; index = addr[3 +: log2(MEM_WORDS)]; upper bits ignored (aliasing wrap).
- proc2mem_data  input  64  store data, sampled at acceptance.
- mem2proc_response  output  4  combinational; assigned tag (1..15) if accepted this cycle, else 0.
- mem2proc_data  output  64  load data, valid only while mem2proc_tag != 0.
- mem2proc_tag  output  4  completing tag, held for exactly one cycle; 0 = no completion.

Behaviour:
- Reset (async): mem2proc_tag=0, mem2proc_data=0, mem2proc_response=0, outstanding count=0, all delay-line stages invalid, next_tag=1. Array contents are not reset. In-flight transactions at reset are discarded and never complete.
- Acceptance condition: command is LOAD or STORE, and outstanding < MAX_OUTSTANDING, and (feature) no injected stall. A completion in the same cycle does not free a slot for that cycle.
- On acceptance:
  - response = next_tag.
  - next_tag advances 1..15 and wraps 15 -> 1; 0 is never issued.
  - {tag, index, is_load} enters delay-line stage 0 at the clock edge.
- Stores write the array at the acceptance edge.
- Loads read the array at completion time, so a load accepted after a store to the same index returns the stored value.
- Rejected or NONE cycle: response = 0; no state change except the stall generator.
- Delay line: MEM_LATENCY stages shifting every cycle. A transaction accepted in cycle T is the last stage in cycle T+MEM_LATENCY.
  - Last stage valid: mem2proc_tag = its tag; mem2proc_data = array[index] for a load, 0 for a store (the tag still returns).
  - Last stage invalid: tag=0, data=0.
- Completions are strictly in order, at most one per cycle.
  - Tags are unique among in-flight transactions because MAX_OUTSTANDING <= 15.
- Outstanding counter: +1 on accept, -1 on completion, unchanged when both occur. It never exceeds MAX_OUTSTANDING and never underflows.
- Full: with MAX_OUTSTANDING < MEM_LATENCY, back-to-back requests see exactly MAX_OUTSTANDING accepts, then rejects until the first completion cycle has passed.
- Acceptance and completion in the same cycle are independent and legal.

Optional Feature:
- Macro: MEM_STALL_INJECT_EN.
- Defined:
  - A 16-bit LFSR (seed 16'hACE1 at reset, polynomial x^16+x^14+x^13+x^11+1) steps every cycle.
  - Any request arriving while lfsr[2:0]==0 is rejected (response 0) even if not full. This exercises initiator retry paths.
- Undefined: no LFSR logic; only the full condition rejects.

Decomposition:
- Shared package (sys_defs):
  - BUS_NONE/BUS_LOAD/BUS_STORE enum.
  - MEM_TAG_W=4 and a MEM_LATENCY default constant.
  - A struct mem_inflight_t {valid, tag[3:0], idx, is_load}.
- Sub-module mem_delay_line: a parameterized MEM_LATENCY-deep shift register of mem_inflight_t with async reset. The top level holds the array, tag counter, outstanding counter and stall LFSR.

Test Plan:
- Reset, single LOAD addr 0x40 in cycle 5 with array[8]=64'hDEAD_BEEF -> response=1 in cycle 5; tag=1, data=64'hDEAD_BEEF in cycle 15 only; tag=0 in cycles 6-14 and 16.
- STORE addr 0x80 data 64'h1234 in cycle 0, LOAD addr 0x80 in cycle 1 -> responses 1 then 2; tag 1 in cycle 10 with data 0; tag 2 in cycle 11 with data 64'h1234.
- LOAD every cycle for 20 cycles (defaults) -> cycles 0-7 get responses 1..8; cycles 8-10 get 0; cycle 11 is accepted with response 9 after the completion of tag 1 in cycle 10.
- 15+ accepted requests spread over time -> tag sequence 1..15, 1, ...; 0 is never issued.
- Assert reset in cycle 3 while 3 loads are in flight -> no nonzero mem2proc_tag afterward; next accepted request gets response 1.
- With MEM_STALL_INJECT_EN, 1000 random requests -> some rejects below full; every accepted tag completes exactly MEM_LATENCY cycles later.
